e203_irq_arbiter: RTL and testbench
===================================

Name: e203_irq_arbiter

Overview:
- Sits between the interrupt synchronizer and the core's trap-entry logic.
- Takes the four synchronized interrupt levels, applies the enables and debug masking, and picks one winner by fixed priority.
- Presents the winner to the core over a valid/ready request interface with a locked cause code.
- After each accepted request, a holdoff interval blocks the same level interrupt from re-issuing before trap entry clears the global enable.

Parameters:
- HOLDOFF_CYC, default 2: cycles spent in HOLD after an accepted request. Legal range 1..255.
- CNT_W, default 8: width of the holdoff counter and the optional latency counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset; asynchronous, active-high (one clock; reset asynchronous active-high).
- ext_irq_r  input  1  synchronized external interrupt level.
- sft_irq_r  input  1  synchronized software interrupt level.
- tmr_irq_r  input  1  synchronized timer interrupt level.
- dbg_irq_r  input  1  synchronized debug request level.
- mstatus_mie  input  1  global machine interrupt enable.
- mie_meie  input  1  external interrupt enable.
- mie_msie  input  1  software interrupt enable.
- mie_mtie  input  1  timer interrupt enable.
- dbg_mode  input  1  core is in debug mode; masks all sources.
- mip_o  output  4  registered pending bits, order {dbg,ext,sft,tmr}.
- irq_req_valid  output  1  request to core.
- irq_req_ready  input  1  core accepts the request.
- irq_req_cause  output  4  mcause code of the locked winner.
- irq_req_is_dbg  output  1  locked winner is debug.
- irq_lat_cnt  output  CNT_W  latency of last accepted request (optional feature only).

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset asserted mid-request drops valid immediately, with no ack implied.
- mip_o is a plain register of the four inputs, one cycle of latency. All arbitration uses mip_o, not the raw inputs.
- Eligibility:
  - dbg_elig = mip_o[3] & !dbg_mode.
  - ext_elig = mip_o[2] & mie_meie & mstatus_mie & !dbg_mode. sft and tmr follow the same pattern with msie and mtie.
- Priority: dbg > ext > sft > tmr.
- Cause codes: ext=11, sft=3, tmr=7, dbg=0 with is_dbg=1.
- State IDLE:
  - If any source is eligible, go to REQ and lock the winner's cause and is_dbg.
  - irq_req_valid rises the next cycle (registered). Worst case is 2 cycles from input level to valid.
- State REQ:
  - irq_req_valid=1. Cause and is_dbg stay stable while valid is high.
  - If valid & ready: the request is accepted; go to HOLD and load the counter with HOLDOFF_CYC-1.
  - If the locked source is no longer eligible and ready=0: withdraw; go to IDLE and drop valid the next cycle. Debug requests are never withdrawn.
  - A higher-priority source arriving in REQ does not preempt. It is served after HOLD.
  - If ready and withdrawal happen in the same cycle, ready wins (accepted).
- State HOLD:
  - valid=0. The counter decrements each cycle; at 0, go to IDLE.
  - HOLDOFF_CYC=1 means exactly one HOLD cycle.
- Invalid state encoding recovers to IDLE.
- irq_req_ready outside REQ is ignored.

Optional Feature:
- Macro: E203_IRQ_ARB_LATENCY_CNT_EN.
- When defined:
  - A saturating CNT_W counter clears on entry to REQ and increments each cycle in REQ.
  - On acceptance its value +1 is latched into irq_lat_cnt, so an accept in the first REQ cycle gives 1.
  - It saturates at all-ones. Reset value is 0.
- When undefined: irq_lat_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package e203_irq_arb_pkg holds:
  - the state enum (IDLE, REQ, HOLD);
  - cause constants CAUSE_EXT=11, CAUSE_SFT=3, CAUSE_TMR=7, CAUSE_DBG=0;
  - the source index constants for mip_o.
- Sub-module e203_irq_arb_prio: purely combinational fixed-priority encoder. It takes a 4-bit eligible vector and returns found, cause and is_dbg.

Test Plan:
- Enables all 1, pulse ext_irq_r high at cycle 10, ready=0 → valid=1 at cycle 12 with cause=11. Raise ready at cycle 15 → valid=0 at cycle 16. With HOLDOFF_CYC=2 the level is re-requested at cycle 19.
- ext, sft, tmr all high in the same cycle → cause=11 first. Then drop ext and pulse ready → next request cause=3.
- Debug priority and masking:
  - tmr in REQ, then dbg rises → no preemption; after accept and HOLD, cause=0 and is_dbg=1.
  - dbg_mode=1 → no valid at all.
- Withdraw: sft request pending with ready=0, clear mie_msie → valid=0 the next cycle, no accept. The same case with ready=1 in the same cycle → accepted.
- Assert rst asynchronously mid-REQ → all outputs 0 immediately. After release, a still-high input re-requests within 2 cycles.
- With E203_IRQ_ARB_LATENCY_CNT_EN: hold ready=0 for 5 REQ cycles, then accept → irq_lat_cnt=6. Hold ready=0 for 300 cycles with CNT_W=8 → irq_lat_cnt=255.

Source files
------------

// File: rtl/e203_irq_arb_pkg.sv
// ============================================================================
// Module      : e203_irq_arb_pkg
// Description : Shared state encoding, mcause codes and mip_o bit indices
//               for the e203 interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package e203_irq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    localparam logic [3:0] CAUSE_EXT = 4'd11;
    localparam logic [3:0] CAUSE_SFT = 4'd3;
    localparam logic [3:0] CAUSE_TMR = 4'd7;
    localparam logic [3:0] CAUSE_DBG = 4'd0;

    // Bit positions within mip_o, ordered {dbg,ext,sft,tmr}
    localparam int c_src_tmr = 0;
    localparam int c_src_sft = 1;
    localparam int c_src_ext = 2;
    localparam int c_src_dbg = 3;

endpackage

`default_nettype wire

// File: rtl/e203_irq_arb_prio.sv
// ============================================================================
// Module      : e203_irq_arb_prio
// Description : Combinational fixed-priority encoder, dbg > ext > sft > tmr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e203_irq_arb_prio
    import e203_irq_arb_pkg::*;
(
    input  logic [3:0] elig,
    output logic       found,
    output logic [3:0] cause,
    output logic       is_dbg
);

    always_comb begin
        found  = 1'b1;
        cause  = CAUSE_DBG;
        is_dbg = 1'b0;
        if (elig[c_src_dbg]) begin
            is_dbg = 1'b1;
        end else if (elig[c_src_ext]) begin
            cause = CAUSE_EXT;
        end else if (elig[c_src_sft]) begin
            cause = CAUSE_SFT;
        end else if (elig[c_src_tmr]) begin
            cause = CAUSE_TMR;
        end else begin
            found = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/e203_irq_arbiter.sv
// ============================================================================
// Module      : e203_irq_arbiter
// Description : Registers interrupt levels, masks them, picks a fixed-priority
//               winner and offers it to the core over valid/ready with a
//               holdoff after each accept. Optional latency counter enabled
//               by E203_IRQ_ARB_LATENCY_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e203_irq_arbiter
    import e203_irq_arb_pkg::*;
#(
    parameter int HOLDOFF_CYC = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_irq_r,
    input  logic             sft_irq_r,
    input  logic             tmr_irq_r,
    input  logic             dbg_irq_r,
    input  logic             mstatus_mie,
    input  logic             mie_meie,
    input  logic             mie_msie,
    input  logic             mie_mtie,
    input  logic             dbg_mode,
    output logic [3:0]       mip_o,
    output logic             irq_req_valid,
    input  logic             irq_req_ready,
    output logic [3:0]       irq_req_cause,
    output logic             irq_req_is_dbg,
    output logic [CNT_W-1:0] irq_lat_cnt
);

    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLDOFF_CYC - 1);

    arb_state_e       r_state;
    logic [3:0]       r_mip;
    logic             r_valid;
    logic [3:0]       r_cause;
    logic             r_is_dbg;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [3:0]       w_elig;
    logic             w_found;
    logic [3:0]       w_cause;
    logic             w_is_dbg;
    logic             w_lock_elig;
    logic             w_accept;

    // Arbitration deliberately sees only the registered levels
    always_comb begin
        w_elig             = '0;
        w_elig[c_src_dbg]  = r_mip[c_src_dbg] & ~dbg_mode;
        w_elig[c_src_ext]  = r_mip[c_src_ext] & mie_meie & mstatus_mie & ~dbg_mode;
        w_elig[c_src_sft]  = r_mip[c_src_sft] & mie_msie & mstatus_mie & ~dbg_mode;
        w_elig[c_src_tmr]  = r_mip[c_src_tmr] & mie_mtie & mstatus_mie & ~dbg_mode;
    end

    e203_irq_arb_prio u_prio (
        .elig   (w_elig),
        .found  (w_found),
        .cause  (w_cause),
        .is_dbg (w_is_dbg)
    );

    // Debug requests are treated as permanently eligible once locked
    always_comb begin
        w_lock_elig = 1'b0;
        if (r_is_dbg) begin
            w_lock_elig = 1'b1;
        end else begin
            case (r_cause)
                CAUSE_EXT: w_lock_elig = w_elig[c_src_ext];
                CAUSE_SFT: w_lock_elig = w_elig[c_src_sft];
                CAUSE_TMR: w_lock_elig = w_elig[c_src_tmr];
                default:   w_lock_elig = 1'b0;
            endcase
        end
    end

    assign w_accept = (r_state == REQ) & r_valid & irq_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mip <= '0;
        end else begin
            r_mip <= {dbg_irq_r, ext_irq_r, sft_irq_r, tmr_irq_r};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_cause    <= '0;
            r_is_dbg   <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state  <= REQ;
                        r_valid  <= 1'b1;
                        r_cause  <= w_cause;
                        r_is_dbg <= w_is_dbg;
                    end
                end
                REQ: begin
                    // Accept takes precedence over a same-cycle withdrawal
                    if (w_accept) begin
                        r_state    <= HOLD;
                        r_valid    <= 1'b0;
                        r_hold_cnt <= c_hold_load;
                    end else if (!w_lock_elig) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef E203_IRQ_ARB_LATENCY_CNT_EN
    logic [CNT_W-1:0] r_lat_run;
    logic [CNT_W-1:0] r_lat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_run <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_lat_run <= '0;
            end else if (r_state == REQ) begin
                if (w_accept) begin
                    r_lat_cnt <= (r_lat_run == '1) ? r_lat_run : r_lat_run + 1'b1;
                end
                if (r_lat_run != '1) begin
                    r_lat_run <= r_lat_run + 1'b1;
                end
            end
        end
    end

    assign irq_lat_cnt = r_lat_cnt;
`else
    assign irq_lat_cnt = '0;
`endif

    assign mip_o          = r_mip;
    assign irq_req_valid  = r_valid;
    assign irq_req_cause  = r_cause;
    assign irq_req_is_dbg = r_is_dbg;

endmodule

`default_nettype wire

// File: tb/tb_e203_irq_arbiter.sv
// ============================================================================
// Module      : tb_e203_irq_arbiter
// Description : Directed self-checking bench with an expected-request queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e203_irq_arbiter;

    typedef struct packed {
        logic [3:0] cause;
        logic       is_dbg;
    } exp_t;

    localparam exp_t c_exp_ext = '{cause: 4'd11, is_dbg: 1'b0};
    localparam exp_t c_exp_sft = '{cause: 4'd3,  is_dbg: 1'b0};
    localparam exp_t c_exp_tmr = '{cause: 4'd7,  is_dbg: 1'b0};
    localparam exp_t c_exp_dbg = '{cause: 4'd0,  is_dbg: 1'b1};

    logic       clk = 1'b0;
    logic       rst;
    logic       ext_irq_r, sft_irq_r, tmr_irq_r, dbg_irq_r;
    logic       mstatus_mie, mie_meie, mie_msie, mie_mtie, dbg_mode;
    logic [3:0] mip_o;
    logic       irq_req_valid;
    logic       irq_req_ready;
    logic [3:0] irq_req_cause;
    logic       irq_req_is_dbg;
    logic [7:0] irq_lat_cnt;

    int   checks = 0;
    int   errors = 0;
    int   vcnt;
    exp_t sb[$];

    e203_irq_arbiter #(.HOLDOFF_CYC(2), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ext_irq_r      (ext_irq_r),
        .sft_irq_r      (sft_irq_r),
        .tmr_irq_r      (tmr_irq_r),
        .dbg_irq_r      (dbg_irq_r),
        .mstatus_mie    (mstatus_mie),
        .mie_meie       (mie_meie),
        .mie_msie       (mie_msie),
        .mie_mtie       (mie_mtie),
        .dbg_mode       (dbg_mode),
        .mip_o          (mip_o),
        .irq_req_valid  (irq_req_valid),
        .irq_req_ready  (irq_req_ready),
        .irq_req_cause  (irq_req_cause),
        .irq_req_is_dbg (irq_req_is_dbg),
        .irq_lat_cnt    (irq_lat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pops the oldest expected request and compares it with what is offered now
    task automatic check_req(input string tag);
        exp_t e;
        chk({tag, "_valid"}, {31'd0, irq_req_valid}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb_empty: observed=0 expected=1 queued entries", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_cause"}, {28'd0, irq_req_cause}, {28'd0, e.cause});
            chk({tag, "_is_dbg"}, {31'd0, irq_req_is_dbg}, {31'd0, e.is_dbg});
        end
    endtask

    task automatic wait_req(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (irq_req_valid) break;
        end
        check_req(tag);
    endtask

    task automatic pulse_ready();
        irq_req_ready = 1'b1;
        tick();
        irq_req_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        {ext_irq_r, sft_irq_r, tmr_irq_r, dbg_irq_r} = '0;
        {mstatus_mie, mie_meie, mie_msie, mie_mtie} = 4'b1111;
        dbg_mode = 1'b0;
        irq_req_ready = 1'b0;
        tick();
        tick();
        chk("rst_mip", {28'd0, mip_o}, 32'd0);
        chk("rst_valid", {31'd0, irq_req_valid}, 32'd0);
        chk("rst_cause", {28'd0, irq_req_cause}, 32'd0);
        chk("rst_is_dbg", {31'd0, irq_req_is_dbg}, 32'd0);
        chk("rst_lat", {24'd0, irq_lat_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic ext request: two-cycle latency, stable hold, holdoff, re-request
        ext_irq_r = 1'b1;
        tick();
        chk("t1_early_valid", {31'd0, irq_req_valid}, 32'd0);
        chk("t1_mip", {28'd0, mip_o}, 32'd4);
        sb.push_back(c_exp_ext);
        tick();
        check_req("t1_first");
        repeat (3) tick();
        chk("t1_stable_valid", {31'd0, irq_req_valid}, 32'd1);
        chk("t1_stable_cause", {28'd0, irq_req_cause}, 32'd11);
        pulse_ready();
        chk("t1_accept_drop", {31'd0, irq_req_valid}, 32'd0);
        sb.push_back(c_exp_ext);
        tick();
        chk("t1_hold1", {31'd0, irq_req_valid}, 32'd0);
        tick();
        chk("t1_hold2", {31'd0, irq_req_valid}, 32'd0);
        tick();
        check_req("t1_rereq");
        ext_irq_r = 1'b0;
        tick();
        chk("t1_wd_pending", {31'd0, irq_req_valid}, 32'd1);
        tick();
        chk("t1_wd_drop", {31'd0, irq_req_valid}, 32'd0);
        repeat (2) tick();
        chk("t1_idle", {31'd0, irq_req_valid}, 32'd0);

        // Simultaneous sources served in priority order
        {ext_irq_r, sft_irq_r, tmr_irq_r} = 3'b111;
        sb.push_back(c_exp_ext);
        wait_req(4, "t2_ext");
        ext_irq_r = 1'b0;
        pulse_ready();
        sb.push_back(c_exp_sft);
        wait_req(6, "t2_sft");
        sft_irq_r = 1'b0;
        pulse_ready();
        sb.push_back(c_exp_tmr);
        wait_req(6, "t2_tmr");
        tmr_irq_r = 1'b0;
        pulse_ready();
        repeat (5) tick();
        chk("t2_idle", {31'd0, irq_req_valid}, 32'd0);

        // Debug arrives during a timer request: no preemption, served next
        tmr_irq_r = 1'b1;
        sb.push_back(c_exp_tmr);
        wait_req(6, "t3_tmr");
        dbg_irq_r = 1'b1;
        repeat (3) tick();
        chk("t3_nopre_cause", {28'd0, irq_req_cause}, 32'd7);
        chk("t3_nopre_dbg", {31'd0, irq_req_is_dbg}, 32'd0);
        tmr_irq_r = 1'b0;
        pulse_ready();
        sb.push_back(c_exp_dbg);
        wait_req(6, "t3_dbg");
        dbg_irq_r = 1'b0;
        repeat (3) tick();
        chk("t3_dbg_kept", {31'd0, irq_req_valid}, 32'd1);
        chk("t3_dbg_kept_flag", {31'd0, irq_req_is_dbg}, 32'd1);
        pulse_ready();
        repeat (5) tick();
        chk("t3_idle", {31'd0, irq_req_valid}, 32'd0);

        // Debug mode masks everything
        dbg_mode = 1'b1;
        ext_irq_r = 1'b1;
        dbg_irq_r = 1'b1;
        vcnt = 0;
        repeat (8) begin
            tick();
            if (irq_req_valid) vcnt++;
        end
        chk("t4_masked", vcnt, 32'd0);
        ext_irq_r = 1'b0;
        dbg_irq_r = 1'b0;
        repeat (2) tick();
        dbg_mode = 1'b0;
        repeat (2) tick();
        chk("t4_idle", {31'd0, irq_req_valid}, 32'd0);

        // Withdrawal without ready, then enable clear racing ready (accept wins)
        sft_irq_r = 1'b1;
        sb.push_back(c_exp_sft);
        wait_req(6, "t5_sft");
        mie_msie = 1'b0;
        tick();
        chk("t5_withdraw", {31'd0, irq_req_valid}, 32'd0);
        mie_msie = 1'b1;
        sb.push_back(c_exp_sft);
        tick();
        check_req("t5_no_holdoff");
        mie_msie = 1'b0;
        pulse_ready();
        chk("t5_acc_drop", {31'd0, irq_req_valid}, 32'd0);
        mie_msie = 1'b1;
        tick();
        chk("t5_acc_hold1", {31'd0, irq_req_valid}, 32'd0);
        tick();
        chk("t5_acc_hold2", {31'd0, irq_req_valid}, 32'd0);
        sb.push_back(c_exp_sft);
        tick();
        check_req("t5_acc_rereq");

        // Asynchronous reset in the middle of a request
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", {31'd0, irq_req_valid}, 32'd0);
        chk("t6_cause", {28'd0, irq_req_cause}, 32'd0);
        chk("t6_is_dbg", {31'd0, irq_req_is_dbg}, 32'd0);
        chk("t6_mip", {28'd0, mip_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.push_back(c_exp_sft);
        wait_req(2, "t6_rereq");

`ifdef E203_IRQ_ARB_LATENCY_CNT_EN
        pulse_ready();
        chk("t7_lat_first", {24'd0, irq_lat_cnt}, 32'd1);
        sb.push_back(c_exp_sft);
        wait_req(6, "t7_req5");
        repeat (5) tick();
        pulse_ready();
        chk("t7_lat_six", {24'd0, irq_lat_cnt}, 32'd6);
        sb.push_back(c_exp_sft);
        wait_req(6, "t7_req300");
        repeat (300) tick();
        pulse_ready();
        chk("t7_lat_sat", {24'd0, irq_lat_cnt}, 32'd255);
`else
        repeat (5) tick();
        pulse_ready();
        chk("t7_lat_tied", {24'd0, irq_lat_cnt}, 32'd0);
`endif
        sft_irq_r = 1'b0;
        repeat (6) tick();
        chk("end_idle", {31'd0, irq_req_valid}, 32'd0);
        chk("end_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
